alu_exec_unit: RTL and testbench

//  Execute stage that consumes the 6-bit ALU control code from the ALU decoder and computes the result.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 214 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, datapath width and mult/div FSM encoding for alu_exec_unit.
// Codes 01xxxx are only implemented when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [5:0] ALU_SLL   = 6'b000000;
    localparam logic [5:0] ALU_BLTZ  = 6'b000000;
    localparam logic [5:0] ALU_BGEZ  = 6'b000001;
    localparam logic [5:0] ALU_SRL   = 6'b000010;
    localparam logic [5:0] ALU_SRA   = 6'b000011;
    localparam logic [5:0] ALU_SLLV  = 6'b000100;
    localparam logic [5:0] ALU_SRLV  = 6'b000110;
    localparam logic [5:0] ALU_SRAV  = 6'b000111;
    localparam logic [5:0] ALU_MFHI  = 6'b010000;
    localparam logic [5:0] ALU_MTHI  = 6'b010001;
    localparam logic [5:0] ALU_MFLO  = 6'b010010;
    localparam logic [5:0] ALU_MTLO  = 6'b010011;
    localparam logic [5:0] ALU_MULT  = 6'b011000;
    localparam logic [5:0] ALU_MULTU = 6'b011001;
    localparam logic [5:0] ALU_DIV   = 6'b011010;
    localparam logic [5:0] ALU_DIVU  = 6'b011011;
    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_SUBU  = 6'b100011;
    localparam logic [5:0] ALU_AND   = 6'b100100;
    localparam logic [5:0] ALU_OR    = 6'b100101;
    localparam logic [5:0] ALU_XOR   = 6'b100110;
    localparam logic [5:0] ALU_NOR   = 6'b100111;
    localparam logic [5:0] ALU_SLT   = 6'b101010;
    localparam logic [5:0] ALU_SLTU  = 6'b101011;
    localparam logic [5:0] ALU_BEQ   = 6'b110000;
    localparam logic [5:0] ALU_BNE   = 6'b110001;
    localparam logic [5:0] ALU_BGTZ  = 6'b110010;
    localparam logic [5:0] ALU_BLEZ  = 6'b110011;
    localparam logic [5:0] ALU_LUI   = 6'b111000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on one 2*WIDTH accumulator.
// Used by alu_exec_unit only when ALU_MULDIV_EN is defined; operands arrive as magnitudes.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH          = ALU_WIDTH,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   acc
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(WIDTH);

    logic               running;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic               mode_div;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   sh;

    assign done = running && (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            running <= !done;
            cnt     <= cnt + 1'b1;
        end
    end

    // Low half holds multiplier / dividend; opnd holds multiplicand / divisor.
    always_ff @(posedge clk) begin
        if (start) begin
            acc      <= {{WIDTH{1'b0}}, op_a};
            opnd     <= op_b;
            mode_div <= is_div;
        end else if (running) begin
            acc <= acc_nxt;
        end
    end

    always_comb begin
        acc_nxt = acc;
        sum     = '0;
        sh      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mode_div) begin
                sh = {acc_nxt, 1'b0};
                if (sh[2*WIDTH:WIDTH] >= {1'b0, opnd}) begin
                    sh[2*WIDTH:WIDTH] = sh[2*WIDTH:WIDTH] - {1'b0, opnd};
                    sh[0]             = 1'b1;
                end
                acc_nxt = sh[2*WIDTH-1:0];
            end else begin
                sum     = {1'b0, acc_nxt[2*WIDTH-1:WIDTH]} + (acc_nxt[0] ? {1'b0, opnd} : '0);
                acc_nxt = {sum, acc_nxt[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: registered single-cycle ALU/branch ops plus optional iterative mult/div with HI/LO.
// Define ALU_MULDIV_EN to build the mult/div engine; otherwise codes 01xxxx report illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH          = ALU_WIDTH,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_ctrl,
    input  logic             is_branch,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             wb_en,
    output logic             br_taken,
    output logic             ovf,
    output logic             illegal,
    output logic             busy
);

    if (WIDTH != 32 || !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("alu_exec_unit: unsupported WIDTH or BITS_PER_CYCLE");
    end

    logic             rdy_q;
    logic             accept;
    logic [WIDTH-1:0] add_r, sub_r;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] res_c;
    logic             wb_c, br_c, ovf_c, ill_c, md_op;
    logic             md_fire;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH-1:0] hi_q, lo_q;

    assign accept  = in_valid && in_ready;
    assign add_r   = op_a + op_b;
    assign sub_r   = op_a - op_b;
    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_r[WIDTH-1] != op_a[WIDTH-1]);
    assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_r[WIDTH-1] != op_a[WIDTH-1]);

    // in_ready stays low for the first cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdy_q <= 1'b0;
        else       rdy_q <= 1'b1;
    end

    always_comb begin
        res_c = '0;
        wb_c  = 1'b1;
        br_c  = 1'b0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        md_op = 1'b0;
        if (is_branch && alu_ctrl[5:1] == 5'd0) begin
            wb_c = 1'b0;
            br_c = (alu_ctrl == ALU_BGEZ) ? !op_a[WIDTH-1] : op_a[WIDTH-1];
        end else begin
            case (alu_ctrl)
                ALU_ADD:  begin res_c = add_r; ovf_c = add_ovf; wb_c = !add_ovf; end
                ALU_ADDU: res_c = add_r;
                ALU_SUB:  begin res_c = sub_r; ovf_c = sub_ovf; wb_c = !sub_ovf; end
                ALU_SUBU: res_c = sub_r;
                ALU_AND:  res_c = op_a & op_b;
                ALU_OR:   res_c = op_a | op_b;
                ALU_XOR:  res_c = op_a ^ op_b;
                ALU_NOR:  res_c = ~(op_a | op_b);
                ALU_SLT:  res_c = WIDTH'($signed(op_a) < $signed(op_b));
                ALU_SLTU: res_c = WIDTH'(op_a < op_b);
                ALU_SLL:  res_c = op_b << shamt;
                ALU_SRL:  res_c = op_b >> shamt;
                ALU_SRA:  res_c = $unsigned($signed(op_b) >>> shamt);
                ALU_SLLV: res_c = op_b << op_a[4:0];
                ALU_SRLV: res_c = op_b >> op_a[4:0];
                ALU_SRAV: res_c = $unsigned($signed(op_b) >>> op_a[4:0]);
                ALU_LUI:  res_c = op_b << 16;
                ALU_BEQ:  begin wb_c = 1'b0; br_c = (op_a == op_b); end
                ALU_BNE:  begin wb_c = 1'b0; br_c = (op_a != op_b); end
                ALU_BGTZ: begin wb_c = 1'b0; br_c = ($signed(op_a) > 0); end
                ALU_BLEZ: begin wb_c = 1'b0; br_c = ($signed(op_a) <= 0); end
`ifdef ALU_MULDIV_EN
                ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: begin md_op = 1'b1; wb_c = 1'b0; end
                ALU_MFHI: res_c = hi_q;
                ALU_MFLO: res_c = lo_q;
                ALU_MTHI, ALU_MTLO: wb_c = 1'b0;
`endif
                default:  begin ill_c = 1'b1; wb_c = 1'b0; end
            endcase
        end
    end

`ifdef ALU_MULDIV_EN
    state_t               state, state_nxt;
    logic                 start, eng_done, op_signed;
    logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0]   eng_acc, prod;
    logic                 md_div, md_neg_q, md_neg_r, md_div0;

    assign start     = accept && md_op;
    assign op_signed = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV);
    assign mag_a     = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b     = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    alu_muldiv_iter #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .is_div (alu_ctrl[1]),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .done   (eng_done),
        .acc    (eng_acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ITER;
            ST_ITER: if (eng_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = rdy_q && (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        md_fire  = (state == ST_DONE);
    end

    // Sign/divide-by-zero context captured at accept for the fix-up in DONE.
    always_ff @(posedge clk) begin
        if (start) begin
            md_div   <= alu_ctrl[1];
            md_neg_q <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            md_neg_r <= op_signed && op_a[WIDTH-1];
            md_div0  <= (op_b == '0);
        end
    end

    always_comb begin
        prod   = md_neg_q ? -eng_acc : eng_acc;
        rem    = md_neg_r ? -eng_acc[2*WIDTH-1:WIDTH] : eng_acc[2*WIDTH-1:WIDTH];
        quo    = md_div0 ? '1 : (md_neg_q ? -eng_acc[WIDTH-1:0] : eng_acc[WIDTH-1:0]);
        md_res = md_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_fire) begin
            hi_q <= md_div ? rem : prod[2*WIDTH-1:WIDTH];
            lo_q <= md_res;
        end else if (accept && !is_branch && alu_ctrl == ALU_MTHI) begin
            hi_q <= op_a;
        end else if (accept && !is_branch && alu_ctrl == ALU_MTLO) begin
            lo_q <= op_a;
        end
    end
`else
    assign in_ready = rdy_q;
    assign busy     = 1'b0;
    assign md_fire  = 1'b0;
    assign md_res   = '0;
    assign hi_q     = '0;
    assign lo_q     = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            wb_en     <= 1'b0;
            br_taken  <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !md_op) begin
            out_valid <= 1'b1;
            result    <= res_c;
            wb_en     <= wb_c;
            br_taken  <= br_c;
            ovf       <= ovf_c;
            illegal   <= ill_c;
        end else if (md_fire) begin
            out_valid <= 1'b1;
            result    <= md_res;
            wb_en     <= 1'b0;
            br_taken  <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            br_taken  <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus mult/div sequences.
// Mult/div sequences are selected by ALU_MULDIV_EN, matching the DUT build.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alu_ctrl = '0;
    logic        is_branch = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        wb_en, br_taken, ovf, illegal, busy;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .is_branch (is_branch),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .result    (result),
        .wb_en     (wb_en),
        .br_taken  (br_taken),
        .ovf       (ovf),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ctrl;
        logic        isb;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        chk_res;
        logic        wb;
        logic        br;
        logic        ov;
        logic        il;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one op and returns #1 after the accepting edge.
    task automatic issue(input logic [5:0] c, input logic isb, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_err++;
            $display("FAIL issue_timeout: in_ready got 0, expected 1");
        end
        alu_ctrl = c; is_branch = isb; op_a = a; op_b = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        n_vec++;
        issue(ALU_MFHI, 1'b0, 32'h0, 32'h0, 5'd0);
        check({tag, ".mfhi"}, {32'h0, result}, {32'h0, exp_hi});
        check({tag, ".mfhi_wb"}, {63'h0, wb_en & out_valid}, 64'h1);
        issue(ALU_MFLO, 1'b0, 32'h0, 32'h0, 5'd0);
        check({tag, ".mflo"}, {32'h0, result}, {32'h0, exp_lo});
    endtask

    // Runs a mult/div to completion, checks latency, in_ready low time and HI/LO.
    task automatic muldiv(input string tag, input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat = 0;
        int nbusy = 0;
        n_vec++;
        issue(c, 1'b0, a, b, 5'd0);
        while (!out_valid && lat < 100) begin
            if (!in_ready) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd33);
        check({tag, ".ready_low"}, 64'(nbusy), 64'd33);
        check({tag, ".wb_en"}, {63'h0, wb_en}, 64'h0);
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        vt.push_back('{ALU_ADD,  1'b0, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{ALU_ADDU, 1'b0, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SUB,  1'b0, 32'h80000000, 32'h00000001, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{ALU_SUBU, 1'b0, 32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_AND,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_OR,   1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 32'hFFFFF0F0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_XOR,  1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 32'hF0F00F0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_NOR,  1'b0, 32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SLT,  1'b0, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SLTU, 1'b0, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SRA,  1'b0, 32'h00000000, 32'h80000000, 5'd4, 32'hF8000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SRL,  1'b0, 32'h00000000, 32'h80000000, 5'd4, 32'h08000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SLL,  1'b0, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SLLV, 1'b0, 32'h00000004, 32'h00000003, 5'd0, 32'h00000030, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SRLV, 1'b0, 32'h00000024, 32'h000000F0, 5'd0, 32'h0000000F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SRAV, 1'b0, 32'h00000001, 32'h80000000, 5'd0, 32'hC0000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_LUI,  1'b0, 32'h00000000, 32'hFFFF1234, 5'd0, 32'h12340000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_BEQ,  1'b0, 32'h00000005, 32'h00000005, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{ALU_BNE,  1'b0, 32'h00000005, 32'h00000005, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_BGTZ, 1'b0, 32'h00000000, 32'h00000000, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_BGTZ, 1'b0, 32'h80000000, 32'h00000000, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_BGTZ, 1'b0, 32'h00000001, 32'h00000000, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{ALU_BLEZ, 1'b0, 32'h00000000, 32'h00000000, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{ALU_BLTZ, 1'b1, 32'hFFFFFFFF, 32'h00000003, 5'd2, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{ALU_BGEZ, 1'b1, 32'h00000000, 32'h00000000, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{ALU_BGEZ, 1'b1, 32'h80000000, 32'h00000000, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{ALU_SLL,  1'b0, 32'hFFFFFFFF, 32'h00000003, 5'd2, 32'h0000000C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{6'b111111, 1'b0, 32'h12345678, 32'h1, 5'd0, 32'h0,              1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{ALU_BGEZ, 1'b0, 32'h12345678, 32'h1, 5'd0, 32'h0,               1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        check("rst.out_valid", {63'h0, out_valid}, 64'h0);
        check("rst.in_ready", {63'h0, in_ready}, 64'h0);
        check("rst.result", {32'h0, result}, 64'h0);
        check("rst.flags", {60'h0, wb_en, br_taken, ovf, illegal}, 64'h0);
        check("rst.busy", {63'h0, busy}, 64'h0);
        reset = 1'b0;
        check("rel.in_ready_low", {63'h0, in_ready}, 64'h0);
        @(posedge clk); #1;
        check("rel.in_ready", {63'h0, in_ready}, 64'h1);

        for (int i = 0; i < vt.size(); i++) begin
            n_vec++;
            issue(vt[i].ctrl, vt[i].isb, vt[i].a, vt[i].b, vt[i].sh);
            check($sformatf("v%0d.out_valid", i), {63'h0, out_valid}, 64'h1);
            if (vt[i].chk_res)
                check($sformatf("v%0d.result", i), {32'h0, result}, {32'h0, vt[i].res});
            check($sformatf("v%0d.wb_en", i), {63'h0, wb_en}, {63'h0, vt[i].wb});
            check($sformatf("v%0d.br_taken", i), {63'h0, br_taken}, {63'h0, vt[i].br});
            check($sformatf("v%0d.ovf", i), {63'h0, ovf}, {63'h0, vt[i].ov});
            check($sformatf("v%0d.illegal", i), {63'h0, illegal}, {63'h0, vt[i].il});
            @(posedge clk); #1;
            check($sformatf("v%0d.pulse", i), {63'h0, out_valid}, 64'h0);
        end

`ifdef ALU_MULDIV_EN
        muldiv("mult", ALU_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        muldiv("multu", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        muldiv("div", ALU_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        muldiv("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        muldiv("divu0", ALU_DIVU, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        muldiv("divmin", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        muldiv("divu", ALU_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

        n_vec++;
        issue(ALU_MTHI, 1'b0, 32'hAAAA5555, 32'h0, 5'd0);
        check("mthi.wb_en", {63'h0, wb_en}, 64'h0);
        issue(ALU_MTLO, 1'b0, 32'h5555AAAA, 32'h0, 5'd0);
        read_hilo("mt", 32'hAAAA5555, 32'h5555AAAA);

        // Reset ten cycles into a divu
        begin
            int seen = 0;
            n_vec++;
            issue(ALU_DIVU, 1'b0, 32'hFFFFFFFF, 32'h00000003, 5'd0);
            check("abort.busy", {63'h0, busy}, 64'h1);
            repeat (9) @(posedge clk);
            #1;
            reset = 1'b1;
            #2;
            check("abort.busy_rst", {63'h0, busy}, 64'h0);
            @(posedge clk); #1;
            reset = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (out_valid) seen++;
                @(posedge clk); #1;
            end
            check("abort.no_out_valid", 64'(seen), 64'd0);
            check("abort.in_ready", {63'h0, in_ready}, 64'h1);
            read_hilo("abort", 32'h0, 32'h0);
        end
`else
        n_vec++;
        issue(ALU_MULT, 1'b0, 32'hFFFFFFFD, 32'h00000005, 5'd0);
        check("mult_off.out_valid", {63'h0, out_valid}, 64'h1);
        check("mult_off.illegal", {63'h0, illegal}, 64'h1);
        check("mult_off.wb_en", {63'h0, wb_en}, 64'h0);
        check("mult_off.busy", {63'h0, busy}, 64'h0);
        check("mult_off.in_ready", {63'h0, in_ready}, 64'h1);
        issue(ALU_MFLO, 1'b0, 32'h0, 32'h0, 5'd0);
        check("mflo_off.illegal", {63'h0, illegal}, 64'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
